// File: rtl/vga_window_ctrl.sv
// VGA display-window controller: issues one FIFO read per window pixel, aligns the
// returned RGB565 data with its coordinate tags and drives RGB888 with mode selection.
module vga_window_ctrl #(
  parameter int unsigned COORD_W  = 11,
  parameter int unsigned H_START  = 50,
  parameter int unsigned V_START  = 1,
  parameter int unsigned WIN_W    = 640,
  parameter int unsigned WIN_H    = 480,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] value_x,
  input  logic [COORD_W-1:0] value_y,
  input  logic [1:0]         mode,
  input  logic [15:0]        rd_q,
  input  logic               fifo_empty,
  output logic               rd_en,
  output logic [23:0]        rgb,
  output logic               de,
  output logic               vga_done,
  output logic               underflow,
  output logic [15:0]        underflow_cnt
);

  typedef enum logic [1:0] {
    MODE_FIFO  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_GRAY  = 2'd3
  } mode_e;

  typedef struct packed {
    logic               inwin;
    logic               starve;
    logic               last;
    mode_e              mode;
    logic [COORD_W-1:0] col;
  } tag_t;

  localparam int unsigned        DEPTH = RD_LAT + 1;
  localparam logic [COORD_W-1:0] H_FIRST = COORD_W'(H_START);
  localparam logic [COORD_W-1:0] V_FIRST = COORD_W'(V_START);
  localparam logic [COORD_W-1:0] BAR_W   = COORD_W'(WIN_W / 8);
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic [COORD_W-1:0] dx, dy;
  logic               inwin, frame_start, fifo_mode;
  mode_e              mode_q, mode_eff;
  tag_t               tag_in, tail;
  tag_t               pipe [DEPTH];
  logic               last_q;

  logic [7:0]  r8, g8, b8, y8;
  logic [15:0] luma;
  logic [2:0]  bar_idx;
  logic [23:0] pix_rgb;

  // Offsets wrap to large values left of / above the window, so one compare per axis.
  always_comb begin
    dx          = value_x - H_FIRST;
    dy          = value_y - V_FIRST;
    inwin       = (dx < COORD_W'(WIN_W)) && (dy < COORD_W'(WIN_H));
    frame_start = (dx == '0) && (dy == '0);
    mode_eff    = frame_start ? mode_e'(mode) : mode_q;
    fifo_mode   = (mode_eff == MODE_FIFO) || (mode_eff == MODE_GRAY);

    tag_in        = '0;
    tag_in.inwin  = inwin;
    tag_in.starve = inwin && fifo_mode && fifo_empty;
    tag_in.last   = inwin && (dx == COORD_W'(WIN_W - 1)) && (dy == COORD_W'(WIN_H - 1));
    tag_in.mode   = mode_eff;
    tag_in.col    = dx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_FIFO;
      rd_en  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      if (frame_start) mode_q <= mode_e'(mode);
      rd_en   <= inwin && fifo_mode && !fifo_empty;
      pipe[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The tail tag lines up with rd_q for the read issued on its behalf.
  always_comb begin
    tail    = pipe[RD_LAT];
    r8      = {rd_q[15:11], rd_q[15:13]};
    g8      = {rd_q[10:5],  rd_q[10:9]};
    b8      = {rd_q[4:0],   rd_q[4:2]};
    luma    = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    y8      = 8'(luma >> 8);
    bar_idx = 3'(tail.col / BAR_W);

    pix_rgb = BG_COLOR;
    if (tail.inwin) begin
      unique case (tail.mode)
        MODE_FIFO:  pix_rgb = tail.starve ? BG_COLOR : {r8, g8, b8};
        MODE_BARS:  pix_rgb = BAR_RGB[bar_idx];
        MODE_SOLID: pix_rgb = BG_COLOR;
        MODE_GRAY:  pix_rgb = tail.starve ? BG_COLOR : {y8, y8, y8};
        default:    pix_rgb = BG_COLOR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb           <= '0;
      de            <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
      last_q        <= 1'b0;
      vga_done      <= 1'b0;
    end else begin
      rgb       <= pix_rgb;
      de        <= tail.inwin;
      underflow <= tail.starve;
      last_q    <= tail.last;
      vga_done  <= last_q;
      if (tail.starve && (underflow_cnt != '1)) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_window_ctrl.sv
// Scoreboard bench: three small-window DUTs (RD_LAT 0/1/3) on a shared raster plus a
// full-frame DUT held starved long enough to saturate its underflow counter.
module tb_vga_window_ctrl;

  localparam int HS = 5, VS = 1, WW = 16, WH = 4, HT = 28, VT = 7;
  localparam int NF = 12, MAXC = 4096;
  localparam logic [23:0] BG = 24'h123456;

  typedef struct {
    int          t;
    logic [23:0] rgb;
    logic        uf;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int tests = 0, fails = 0;

  logic        rst = 1'b1;
  logic [10:0] vx = '0, vy = '0;
  logic [1:0]  mode_in = '0;
  logic        empty = 1'b0;
  logic [15:0] rd_q [3];
  logic        rd_en [3];
  logic [23:0] rgb [3];
  logic        de [3], done [3], uf [3];
  logic [15:0] ucnt [3];

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    vga_window_ctrl #(
      .COORD_W(11), .H_START(HS), .V_START(VS), .WIN_W(WW), .WIN_H(WH),
      .RD_LAT(L), .BG_COLOR(BG)
    ) u_dut (
      .clk(clk), .rst(rst), .value_x(vx), .value_y(vy), .mode(mode_in),
      .rd_q(rd_q[g]), .fifo_empty(empty), .rd_en(rd_en[g]), .rgb(rgb[g]),
      .de(de[g]), .vga_done(done[g]), .underflow(uf[g]), .underflow_cnt(ucnt[g])
    );
  end

  logic        rst4 = 1'b1;
  logic [10:0] x4 = '0, y4 = '0;
  logic        rd_en4, de4, done4, uf4;
  logic [23:0] rgb4;
  logic [15:0] cnt4;

  vga_window_ctrl #(
    .COORD_W(11), .H_START(0), .V_START(0), .WIN_W(256), .WIN_H(256),
    .RD_LAT(1), .BG_COLOR(BG)
  ) u_sat (
    .clk(clk), .rst(rst4), .value_x(x4), .value_y(y4), .mode(2'd0),
    .rd_q(16'h0000), .fifo_empty(1'b1), .rd_en(rd_en4), .rgb(rgb4),
    .de(de4), .vga_done(done4), .underflow(uf4), .underflow_cnt(cnt4)
  );

  exp_t        sb [$];
  int          rd_hist [3][MAXC];
  logic        rst_hist [MAXC];
  logic [15:0] data_mem [4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [23:0] to888(input logic [15:0] w);
    int r, g, b;
    r = int'(w[15:11]); g = int'(w[10:5]); b = int'(w[4:0]);
    return 24'(((r * 8 + r / 4) << 16) | ((g * 4 + g / 16) << 8) | (b * 8 + b / 4));
  endfunction

  function automatic logic [23:0] to_gray(input logic [23:0] c);
    int y;
    y = (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) / 256;
    return {8'(y), 8'(y), 8'(y)};
  endfunction

  function automatic logic [23:0] bar_color(input int col);
    case (col / (WW / 8))
      0: return 24'hFFFFFF;  1: return 24'hFFFF00;
      2: return 24'h00FFFF;  3: return 24'h00FF00;
      4: return 24'hFF00FF;  5: return 24'hFF0000;
      6: return 24'h0000FF;  default: return 24'h000000;
    endcase
  endfunction

  function automatic logic killed(input int t, input int l);
    for (int r = t; r <= t + l + 1; r++)
      if (r < MAXC && rst_hist[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_main();
    int plan [NF+1] = '{0, 0, 1, 3, 2, 0, 3, 1, 0, 3, 1, 2, 0};
    int ekind [NF]  = '{0, 2, 0, 1, 1, 1, 1, 0, 2, 1, 1, 0};
    logic       rden_prev [3];
    logic       exp_rd, inw, fs, fmode, starve;
    logic [1:0] mode_model;
    int         m, c, x, y, f, p, idx, nsteps;
    exp_t       e;
    exp_rd = 1'b0; mode_model = 2'd0; m = 0;
    for (int g = 0; g < 3; g++) rden_prev[g] = 1'b0;
    nsteps = 3 + NF * HT * VT + 12;
    for (int s = 0; s < nsteps; s++) begin
      @(posedge clk); #1;
      c = cyc;
      for (int g = 0; g < 3; g++) begin
        rd_hist[g][c] = rd_hist[g][c-1] + (rden_prev[g] ? 1 : 0);
        rden_prev[g]  = rd_en[g];
        idx = (c - lat_of(g) >= 0) ? rd_hist[g][c - lat_of(g)] : 0;
        rd_q[g] = data_mem[idx % 4096];
        check("rd_en", rd_en[g], exp_rd);
        if (rst_hist[c-1]) begin
          check("rst_rgb", rgb[g], 24'h0);
          check("rst_de", de[g], 1'b0);
          check("rst_done", done[g], 1'b0);
          check("rst_uf", uf[g], 1'b0);
          check("rst_cnt", ucnt[g], 16'h0);
        end
      end
      if (s < 3 || s >= 3 + NF * HT * VT) begin
        x = 0; y = 0; f = NF; rst = (s < 3);
        mode_in = 2'(plan[NF]); empty = 1'b0;
      end else begin
        p = s - 3; f = p / (HT * VT); x = p % HT; y = (p / HT) % VT;
        rst     = (f == 7 && y == 2 && x == 10);
        mode_in = 2'((y < 3) ? plan[f] : plan[f+1]);
        case (ekind[f])
          1:       empty = ($urandom_range(0, 5) == 0);
          2:       empty = (y == 2 && x >= HS + 3 && x < HS + 8);
          default: empty = 1'b0;
        endcase
      end
      vx = 11'(x); vy = 11'(y);
      rst_hist[c] = rst;

      inw = (x >= HS && x < HS + WW && y >= VS && y < VS + WH);
      fs  = (x == HS && y == VS);
      if (rst) mode_model = 2'd0;
      else if (fs) mode_model = mode_in;
      fmode  = (mode_model == 2'd0 || mode_model == 2'd3);
      starve = !rst && inw && fmode && empty;
      exp_rd = !rst && inw && fmode && !empty;
      if (!rst && inw) begin
        e.t = c; e.uf = starve;
        e.last = (x == HS + WW - 1 && y == VS + WH - 1);
        case (mode_model)
          2'd0:    e.rgb = starve ? BG : to888(data_mem[m % 4096]);
          2'd1:    e.rgb = bar_color(x - HS);
          2'd3:    e.rgb = starve ? BG : to_gray(to888(data_mem[m % 4096]));
          default: e.rgb = BG;
        endcase
        sb.push_back(e);
      end
      if (exp_rd) m++;
    end
  endtask

  task automatic run_sat();
    int p, expc;
    for (int i = 0; i <= 65600; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        check("sat_rst_cnt", cnt4, 16'h0);
        check("sat_rst_de", de4, 1'b0);
        check("sat_rst_rgb", rgb4, 24'h0);
      end
      if (i == 1003 || i == 65537 || i == 65538 || i == 65600) begin
        expc = (i - 3 > 65535) ? 65535 : i - 3;
        check("sat_cnt", cnt4, 32'(expc));
        check("sat_uf", uf4, 1'b1);
        check("sat_de", de4, 1'b1);
        check("sat_rgb", rgb4, BG);
        check("sat_rd_en", rd_en4, 1'b0);
      end
      rst4 = (i == 0);
      p = (i == 0) ? 0 : i - 1;
      x4 = 11'(p % 256);
      y4 = 11'((p / 256) % 256);
    end
  endtask

  int   ptr [3] = '{0, 0, 0};
  int   done_at [3] = '{-1, -1, -1};
  int   ecnt [3] = '{0, 0, 0};
  exp_t me;
  logic exp_de;

  initial begin
    forever begin
      @(posedge clk); #3;
      for (int g = 0; g < 3; g++) begin
        if (cyc - 1 < MAXC && rst_hist[cyc-1]) ecnt[g] = 0;
        while (ptr[g] < sb.size() && sb[ptr[g]].t + lat_of(g) + 2 < cyc) ptr[g]++;
        exp_de = 1'b0;
        if (ptr[g] < sb.size() && sb[ptr[g]].t + lat_of(g) + 2 == cyc) begin
          me = sb[ptr[g]];
          ptr[g]++;
          exp_de = !killed(me.t, lat_of(g));
        end
        check("de", de[g], exp_de);
        if (exp_de && de[g]) begin
          if (me.uf && ecnt[g] < 65535) ecnt[g]++;
          check("rgb", rgb[g], me.rgb);
          check("underflow", uf[g], me.uf);
          check("underflow_cnt", ucnt[g], 32'(ecnt[g]));
          if (me.last) done_at[g] = cyc + 1;
        end
        check("vga_done", done[g], cyc == done_at[g]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) data_mem[i] = 16'($urandom);
    data_mem[0] = 16'h8410; data_mem[1] = 16'hFFFF; data_mem[2] = 16'hF800;
    data_mem[3] = 16'h07E0; data_mem[4] = 16'h001F;
    for (int g = 0; g < 3; g++) begin
      rd_q[g] = '0;
      for (int i = 0; i < MAXC; i++) rd_hist[g][i] = 0;
    end
    for (int i = 0; i < MAXC; i++) rst_hist[i] = 1'b0;
    rst_hist[0] = 1'b1;
    fork
      run_main();
      run_sat();
    join
    repeat (2) @(posedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
